// File: rtl/mdu_hilo.sv
// Multiply/divide unit with HI/LO registers: computes the result at issue,
// holds it pending for a fixed latency, then commits to HI/LO.
module mdu_hilo #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wdata,
  input  logic        rd_sel,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        stall
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  logic [31:0]   hi, lo, pend_hi, pend_lo;
  logic [CW-1:0] cnt;

  logic signed [63:0] sprod;
  logic [63:0]        uprod;
  logic               sdiv, qneg;
  logic [31:0]        ma, mb, uq, ur;
  logic [31:0]        res_hi, res_lo;
  logic               accept;

  assign accept = start & ~busy;
  assign stall  = busy | start;
  assign rdata  = rd_sel ? hi : lo;

  assign sprod = $signed(a) * $signed(b);
  assign uprod = {32'b0, a} * {32'b0, b};

  // Signed divide runs on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign sdiv = ~op[0];
  assign qneg = sdiv & (a[31] ^ b[31]);
  assign ma   = (sdiv & a[31]) ? -a : a;
  assign mb   = (sdiv & b[31]) ? -b : b;

  always_comb begin
    uq = '0;
    ur = '0;
    if (mb != '0) begin
      uq = ma / mb;
      ur = ma % mb;
    end
  end

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    if (!op[1]) begin
      res_hi = op[0] ? uprod[63:32] : sprod[63:32];
      res_lo = op[0] ? uprod[31:0]  : sprod[31:0];
    end else if (b == '0) begin
      res_hi = a;
      res_lo = 32'hFFFF_FFFF;
    end else begin
      res_lo = qneg ? -uq : uq;
      res_hi = (sdiv & a[31]) ? -ur : ur;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
    end else if (busy) begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        busy <= 1'b0;
        hi   <= pend_hi;
        lo   <= pend_lo;
      end
    end else if (accept) begin
      pend_hi <= res_hi;
      pend_lo <= res_lo;
      cnt     <= op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      busy    <= 1'b1;
    end else begin
      if (wr_hi) hi <= wdata;
      if (wr_lo) lo <= wdata;
    end
  end
endmodule
